axil_master_bridge: RTL and testbench
=====================================

# axil_master_bridge

Single-outstanding bridge from the core-side request/response memory port to one AXI-Lite master port. It feeds one slave interface of the SoC AXI-Lite interconnect. Each accepted core request becomes exactly one AXI-Lite read or write, unless it is misaligned. The AXI response is returned to the core as a one-cycle response pulse.

## Interface
- `ADDR_WIDTH`, 32, address width of the core port and the AXI port.
- `DATA_WIDTH`, 32, data width; only 32 is supported.
- `STRB_WIDTH`, DATA_WIDTH/8, byte-enable / wstrb width.
- `AXI_PROT`, 3'b000, constant driven on awprot/arprot.
- `clk_i` in 1: single clock; all logic is rising-edge.
- `reset_i` in 1: synchronous, active-high reset.
- `req_valid_i` in 1: core request valid.
- `req_ready_o` out 1: bridge can accept a request.
- `req_we_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in ADDR_WIDTH: byte address.
- `req_wdata_i` in DATA_WIDTH: write data.
- `req_be_i` in STRB_WIDTH: byte enables.
- `rsp_valid_o` out 1: one-cycle response pulse; no backpressure.
- `rsp_rdata_o` out DATA_WIDTH: read data, valid with `rsp_valid_o`.
- `rsp_err_o` out 1: error flag, valid with `rsp_valid_o`.
- `m_axil_awaddr`/`awprot`/`awvalid` out, `m_axil_awready` in: AW channel.
- `m_axil_wdata`/`wstrb`/`wvalid` out, `m_axil_wready` in: W channel.
- `m_axil_bresp` in 2, `m_axil_bvalid` in 1, `m_axil_bready` out 1: B channel.
- `m_axil_araddr`/`arprot`/`arvalid` out, `m_axil_arready` in: AR channel.
- `m_axil_rdata` in DATA_WIDTH, `m_axil_rresp` in 2, `m_axil_rvalid` in 1, `m_axil_rready` out 1: R channel.

## Operation
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- `req_ready_o` = (state == IDLE). This is combinational from state only.
- Accept: `req_valid_i && req_ready_o`. On accept, addr, wdata, be and we are captured into registers.
- Misaligned accept (`req_addr_i[1:0] != 0`):
  - No AXI transaction is issued.
  - Go to RESP with err=1 and rdata=0.
- Aligned write accept: go to WR_ADDR_DATA with `awvalid` and `wvalid` both set.
  - Each valid drops independently on its own handshake (tracked by aw_done/w_done).
  - When both channels are done, go to WR_RESP. Same-cycle completion of both is legal.
- WR_RESP: `bready` = 1.
  - On `bvalid`: err = `bresp[1]`, rdata = 0, go to RESP.
- Aligned read accept: go to RD_ADDR with `arvalid` = 1.
  - On `arready`: go to RD_DATA.
- RD_DATA: `rready` = 1.
  - On `rvalid`: rdata = `m_axil_rdata`, err = `rresp[1]`, go to RESP.
- RESP: `rsp_valid_o` = 1 for exactly one cycle, then IDLE.
- Error mapping: OKAY and EXOKAY give err=0; SLVERR and DECERR give err=1.
- AXI outputs are registered. awaddr/araddr/wdata/wstrb hold the captured values, stable while valid is high.
- Valid signals never drop without a handshake.
- awprot/arprot = `AXI_PROT` at all times.

## Timing
- Reset values:
  - state = IDLE, so `req_ready_o` = 1.
  - `rsp_valid_o`, `rsp_err_o`, all AXI valids, `bready`, `rready` = 0.
  - `rsp_rdata_o`, captured addr/data/strb = 0.
- Reset mid-transaction: abandons the transaction at once and returns to IDLE, with no response pulse.
  - The interconnect must share `reset_i`.
- Cycle 0 is the accept cycle. AW/W/AR valid is visible from cycle 1.
- With a zero-wait slave (ready=1, response the cycle after the address):
  - Write: AW+W handshake in cycle 1, B handshake in cycle 2, `rsp_valid_o` in cycle 3.
  - Read: AR in cycle 1, R in cycle 2, `rsp_valid_o` in cycle 3.
  - The next accept is possible in cycle 4.
- Misaligned request: `rsp_valid_o` in cycle 1, next accept in cycle 2.
- `bready`/`rready` are asserted only in WR_RESP/RD_DATA. A B/R beat arriving early is not accepted until then.
- Throughput is at most one transaction per 4 cycles (aligned). There is no pipelining and only one transaction is outstanding.

## Test plan
- Aligned write, addr=0x0000_1000, wdata=0xDEADBEEF, be=0xF, zero-wait slave, bresp=OKAY:
  - awaddr=0x1000, wdata=0xDEADBEEF, wstrb=0xF seen in cycle 1.
  - `rsp_valid_o` in cycle 3 with err=0.
  - `req_ready_o` is low during cycles 1-3.
- Aligned read, addr=0x0000_2004, rdata=0x12345678, rresp=OKAY:
  - araddr=0x2004 in cycle 1.
  - `rsp_rdata_o`=0x12345678 with err=0 in cycle 3.
- Write where awready is delayed 3 cycles and wready is immediate:
  - wvalid drops after cycle 1; awvalid holds with a stable address until cycle 4.
  - bready rises only after both handshakes.
  - Exactly one response pulse.
- Error responses:
  - Read with rresp=DECERR gives err=1.
  - Write with bresp=SLVERR gives err=1.
  - Write with bresp=EXOKAY gives err=0.
- Misaligned read, addr=0x0000_3002:
  - No AXI valid is ever asserted.
  - `rsp_valid_o` in cycle 1 with err=1 and rdata=0.
- `reset_i` asserted while in RD_DATA:
  - Next cycle: IDLE, arvalid=rready=0, `req_ready_o`=1, no `rsp_valid_o`.
  - A new read then completes normally.

Source files
------------

// File: rtl/axil_master_bridge.sv
// Single-outstanding bridge from the core request/response port to one AXI-Lite master.
// Misaligned requests are answered locally with an error and never reach the bus.
module axil_master_bridge #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter int         STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0] AXI_PROT   = 3'b000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  // core request/response port
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [STRB_WIDTH-1:0] req_be_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  // AXI-Lite master port
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_WIDTH-1:0]   r_be;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_arvalid;
  logic                    r_bready;
  logic                    r_rready;
  logic                    r_aw_done;
  logic                    r_w_done;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_err;

  logic                    w_accept;
  logic                    w_misaligned;
  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_ar_hs;
  logic                    w_b_hs;
  logic                    w_r_hs;
  logic                    w_unused;

  assign w_accept     = req_valid_i && (r_state == IDLE);
  assign w_misaligned = (req_addr_i[1:0] != 2'b00);
  assign w_aw_hs      = r_awvalid && m_axil_awready;
  assign w_w_hs       = r_wvalid && m_axil_wready;
  assign w_ar_hs      = r_arvalid && m_axil_arready;
  assign w_b_hs       = r_bready && m_axil_bvalid;
  assign w_r_hs       = r_rready && m_axil_rvalid;
  // Only bit 1 of a response distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  assign w_unused     = ^{m_axil_bresp[0], m_axil_rresp[0]};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid_i) begin
          if (w_misaligned)  w_next_state = RESP;
          else if (req_we_i) w_next_state = WR_ADDR_DATA;
          else               w_next_state = RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next_state = WR_RESP;
      end
      WR_RESP:  if (w_b_hs)  w_next_state = RESP;
      RD_ADDR:  if (w_ar_hs) w_next_state = RD_DATA;
      RD_DATA:  if (w_r_hs)  w_next_state = RESP;
      RESP:     w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr    <= req_addr_i;
        r_wdata   <= req_wdata_i;
        r_be      <= req_be_i;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_awvalid <= !w_misaligned && req_we_i;
        r_wvalid  <= !w_misaligned && req_we_i;
        r_arvalid <= !w_misaligned && !req_we_i;
        if (w_misaligned) begin
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b1;
        end
      end
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_wvalid <= 1'b0;
        r_w_done <= 1'b1;
      end
      if (w_ar_hs) begin
        r_arvalid <= 1'b0;
      end
      // Response readies follow the state they belong to, so early beats are ignored.
      r_bready <= (w_next_state == WR_RESP);
      r_rready <= (w_next_state == RD_DATA);
      if (w_b_hs) begin
        r_rsp_rdata <= '0;
        r_rsp_err   <= m_axil_bresp[1];
      end
      if (w_r_hs) begin
        r_rsp_rdata <= m_axil_rdata;
        r_rsp_err   <= m_axil_rresp[1];
      end
    end
  end

  assign req_ready_o    = (r_state == IDLE);
  assign rsp_valid_o    = (r_state == RESP);
  assign rsp_rdata_o    = r_rsp_rdata;
  assign rsp_err_o      = r_rsp_err;

  assign m_axil_awaddr  = r_addr;
  assign m_axil_awprot  = AXI_PROT;
  assign m_axil_awvalid = r_awvalid;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wstrb   = r_be;
  assign m_axil_wvalid  = r_wvalid;
  assign m_axil_bready  = r_bready;
  assign m_axil_araddr  = r_addr;
  assign m_axil_arprot  = AXI_PROT;
  assign m_axil_arvalid = r_arvalid;
  assign m_axil_rready  = r_rready;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Directed bench for axil_master_bridge: the bench plays the AXI-Lite slave cycle by cycle
// and checks every output against hand-computed values with immediate assertions.
module tb_axil_master_bridge;

  logic        clk;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [3:0]  reqBe;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic        rspErr;
  logic [31:0] awAddr;
  logic [2:0]  awProt;
  logic        awValid;
  logic        awReady;
  logic [31:0] wData;
  logic [3:0]  wStrb;
  logic        wValid;
  logic        wReady;
  logic [1:0]  bResp;
  logic        bValid;
  logic        bReady;
  logic [31:0] arAddr;
  logic [2:0]  arProt;
  logic        arValid;
  logic        arReady;
  logic [31:0] rData;
  logic [1:0]  rResp;
  logic        rValid;
  logic        rReady;

  int checks = 0;
  int errors = 0;

  axil_master_bridge dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .req_valid_i    (reqValid),
    .req_ready_o    (reqReady),
    .req_we_i       (reqWe),
    .req_addr_i     (reqAddr),
    .req_wdata_i    (reqWdata),
    .req_be_i       (reqBe),
    .rsp_valid_o    (rspValid),
    .rsp_rdata_o    (rspRdata),
    .rsp_err_o      (rspErr),
    .m_axil_awaddr  (awAddr),
    .m_axil_awprot  (awProt),
    .m_axil_awvalid (awValid),
    .m_axil_awready (awReady),
    .m_axil_wdata   (wData),
    .m_axil_wstrb   (wStrb),
    .m_axil_wvalid  (wValid),
    .m_axil_wready  (wReady),
    .m_axil_bresp   (bResp),
    .m_axil_bvalid  (bValid),
    .m_axil_bready  (bReady),
    .m_axil_araddr  (arAddr),
    .m_axil_arprot  (arProt),
    .m_axil_arvalid (arValid),
    .m_axil_arready (arReady),
    .m_axil_rdata   (rData),
    .m_axil_rresp   (rResp),
    .m_axil_rvalid  (rValid),
    .m_axil_rready  (rReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Every step starts 1ns after a rising edge: outputs of the new cycle are settled here.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    reqValid = 1'b1;
    reqWe    = we;
    reqAddr  = addr;
    reqWdata = wdata;
    reqBe    = be;
  endtask

  // Entered in the accept cycle (cycle 0); returns in cycle 4, where the next accept may happen.
  task automatic zeroWaitWrite(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [1:0] resp, input logic expErr);
    checkOutput({tag, ".c0.ready"}, reqReady, 1);
    applyStimulus(1'b1, addr, wdata, be);
    awReady = 1'b1;
    wReady  = 1'b1;
    nextCycle();
    reqValid = 1'b0;
    checkOutput({tag, ".c1.awvalid"}, awValid, 1);
    checkOutput({tag, ".c1.wvalid"}, wValid, 1);
    checkOutput({tag, ".c1.awaddr"}, awAddr, addr);
    checkOutput({tag, ".c1.wdata"}, wData, wdata);
    checkOutput({tag, ".c1.wstrb"}, wStrb, be);
    checkOutput({tag, ".c1.ready"}, reqReady, 0);
    checkOutput({tag, ".c1.bready"}, bReady, 0);
    nextCycle();
    checkOutput({tag, ".c2.awvalid"}, awValid, 0);
    checkOutput({tag, ".c2.wvalid"}, wValid, 0);
    checkOutput({tag, ".c2.bready"}, bReady, 1);
    checkOutput({tag, ".c2.rspvalid"}, rspValid, 0);
    checkOutput({tag, ".c2.ready"}, reqReady, 0);
    bValid = 1'b1;
    bResp  = resp;
    nextCycle();
    bValid = 1'b0;
    bResp  = 2'b00;
    checkOutput({tag, ".c3.rspvalid"}, rspValid, 1);
    checkOutput({tag, ".c3.err"}, rspErr, expErr);
    checkOutput({tag, ".c3.rdata"}, rspRdata, 0);
    checkOutput({tag, ".c3.ready"}, reqReady, 0);
    checkOutput({tag, ".c3.bready"}, bReady, 0);
    nextCycle();
    checkOutput({tag, ".c4.rspvalid"}, rspValid, 0);
  endtask

  task automatic zeroWaitRead(input string tag, input logic [31:0] addr, input logic [31:0] rdata,
                              input logic [1:0] resp, input logic expErr);
    checkOutput({tag, ".c0.ready"}, reqReady, 1);
    applyStimulus(1'b0, addr, 32'h0, 4'h0);
    arReady = 1'b1;
    nextCycle();
    reqValid = 1'b0;
    checkOutput({tag, ".c1.arvalid"}, arValid, 1);
    checkOutput({tag, ".c1.araddr"}, arAddr, addr);
    checkOutput({tag, ".c1.rready"}, rReady, 0);
    checkOutput({tag, ".c1.awvalid"}, awValid, 0);
    checkOutput({tag, ".c1.ready"}, reqReady, 0);
    nextCycle();
    checkOutput({tag, ".c2.arvalid"}, arValid, 0);
    checkOutput({tag, ".c2.rready"}, rReady, 1);
    checkOutput({tag, ".c2.rspvalid"}, rspValid, 0);
    rValid = 1'b1;
    rData  = rdata;
    rResp  = resp;
    nextCycle();
    rValid = 1'b0;
    rData  = 32'h0;
    rResp  = 2'b00;
    checkOutput({tag, ".c3.rspvalid"}, rspValid, 1);
    checkOutput({tag, ".c3.rdata"}, rspRdata, rdata);
    checkOutput({tag, ".c3.err"}, rspErr, expErr);
    checkOutput({tag, ".c3.rready"}, rReady, 0);
    nextCycle();
    checkOutput({tag, ".c4.rspvalid"}, rspValid, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the directed sequence finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset    = 1'b1;
    reqValid = 1'b0;
    reqWe    = 1'b0;
    reqAddr  = 32'h0;
    reqWdata = 32'h0;
    reqBe    = 4'h0;
    awReady  = 1'b0;
    wReady   = 1'b0;
    bResp    = 2'b00;
    bValid   = 1'b0;
    arReady  = 1'b0;
    rData    = 32'h0;
    rResp    = 2'b00;
    rValid   = 1'b0;
    nextCycle();
    nextCycle();

    checkOutput("rst.ready", reqReady, 1);
    checkOutput("rst.rspvalid", rspValid, 0);
    checkOutput("rst.rspdata", rspRdata, 0);
    checkOutput("rst.rsperr", rspErr, 0);
    checkOutput("rst.awvalid", awValid, 0);
    checkOutput("rst.wvalid", wValid, 0);
    checkOutput("rst.arvalid", arValid, 0);
    checkOutput("rst.bready", bReady, 0);
    checkOutput("rst.rready", rReady, 0);
    checkOutput("rst.awaddr", awAddr, 0);
    checkOutput("rst.wdata", wData, 0);
    checkOutput("rst.wstrb", wStrb, 0);
    checkOutput("rst.awprot", awProt, 0);
    checkOutput("rst.arprot", arProt, 0);
    reset = 1'b0;
    nextCycle();

    zeroWaitWrite("wr1", 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 2'b00, 1'b0);
    zeroWaitRead("rd1", 32'h0000_2004, 32'h1234_5678, 2'b00, 1'b0);

    // awready held off for three cycles while W completes immediately
    checkOutput("dly.c0.ready", reqReady, 1);
    applyStimulus(1'b1, 32'h0000_4008, 32'hCAFE_F00D, 4'h3);
    awReady = 1'b0;
    wReady  = 1'b1;
    nextCycle();
    reqValid = 1'b0;
    checkOutput("dly.c1.awvalid", awValid, 1);
    checkOutput("dly.c1.wvalid", wValid, 1);
    nextCycle();
    checkOutput("dly.c2.wvalid", wValid, 0);
    checkOutput("dly.c2.awvalid", awValid, 1);
    checkOutput("dly.c2.awaddr", awAddr, 32'h0000_4008);
    checkOutput("dly.c2.bready", bReady, 0);
    checkOutput("dly.c2.rspvalid", rspValid, 0);
    nextCycle();
    checkOutput("dly.c3.awvalid", awValid, 1);
    checkOutput("dly.c3.awaddr", awAddr, 32'h0000_4008);
    checkOutput("dly.c3.bready", bReady, 0);
    checkOutput("dly.c3.rspvalid", rspValid, 0);
    nextCycle();
    checkOutput("dly.c4.awvalid", awValid, 1);
    checkOutput("dly.c4.awaddr", awAddr, 32'h0000_4008);
    checkOutput("dly.c4.wstrb", wStrb, 4'h3);
    checkOutput("dly.c4.bready", bReady, 0);
    awReady = 1'b1;
    nextCycle();
    checkOutput("dly.c5.awvalid", awValid, 0);
    checkOutput("dly.c5.bready", bReady, 1);
    checkOutput("dly.c5.rspvalid", rspValid, 0);
    bValid = 1'b1;
    bResp  = 2'b00;
    nextCycle();
    bValid = 1'b0;
    checkOutput("dly.c6.rspvalid", rspValid, 1);
    checkOutput("dly.c6.err", rspErr, 0);
    nextCycle();
    checkOutput("dly.c7.rspvalid", rspValid, 0);
    checkOutput("dly.c7.ready", reqReady, 1);

    zeroWaitRead("rdDecerr", 32'h0000_7000, 32'hBAD0_BAD0, 2'b11, 1'b1);
    zeroWaitWrite("wrSlverr", 32'h0000_7004, 32'h0000_00AA, 4'h1, 2'b10, 1'b1);
    zeroWaitWrite("wrExokay", 32'h0000_7008, 32'h5555_AAAA, 4'hC, 2'b01, 1'b0);
    zeroWaitRead("rd2", 32'h0000_200C, 32'hA5A5_0001, 2'b00, 1'b0);

    // misaligned read answered locally; previous nonzero rdata must be cleared
    checkOutput("mis.c0.ready", reqReady, 1);
    applyStimulus(1'b0, 32'h0000_3002, 32'h0, 4'h0);
    nextCycle();
    reqValid = 1'b0;
    checkOutput("mis.c1.rspvalid", rspValid, 1);
    checkOutput("mis.c1.err", rspErr, 1);
    checkOutput("mis.c1.rdata", rspRdata, 0);
    checkOutput("mis.c1.arvalid", arValid, 0);
    checkOutput("mis.c1.awvalid", awValid, 0);
    checkOutput("mis.c1.wvalid", wValid, 0);
    checkOutput("mis.c1.ready", reqReady, 0);
    nextCycle();
    checkOutput("mis.c2.rspvalid", rspValid, 0);
    checkOutput("mis.c2.arvalid", arValid, 0);
    checkOutput("mis.c2.ready", reqReady, 1);

    // reset while waiting for read data
    applyStimulus(1'b0, 32'h0000_5000, 32'h0, 4'h0);
    arReady = 1'b1;
    nextCycle();
    reqValid = 1'b0;
    checkOutput("rstMid.c1.arvalid", arValid, 1);
    nextCycle();
    checkOutput("rstMid.c2.rready", rReady, 1);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    checkOutput("rstMid.c3.ready", reqReady, 1);
    checkOutput("rstMid.c3.arvalid", arValid, 0);
    checkOutput("rstMid.c3.rready", rReady, 0);
    checkOutput("rstMid.c3.rspvalid", rspValid, 0);
    nextCycle();
    checkOutput("rstMid.c4.rspvalid", rspValid, 0);

    zeroWaitRead("rdAfterRst", 32'h0000_6000, 32'h0F0F_1234, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
